// File: rtl/enabler_pkg.sv
// Shared constants and types for the enabler data gate.
package enabler_pkg;

    localparam int MAX_BUFFER = 8;

    typedef enum logic {
        HOLD_ZERO = 1'b0,
        HOLD_LAST = 1'b1
    } hold_mode_e;

endpackage

// File: rtl/enabler_if.sv
// Gated data bus: the enable strobe, the raw word and the qualified word.
interface enabler_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    modport master (
        output enable,
        output in,
        input  out
    );

    modport slave (
        input  enable,
        input  in,
        output out
    );
endinterface

// File: rtl/enabler_stage.sv
// One WIDTH-bit register with load enable, cleared by the asynchronous active-low reset.
module enabler_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/enabler.sv
// Data gate: passes the bus while enabled, otherwise zeros or the last enabled word,
// optionally followed by BUFFER register stages.
module enabler
    import enabler_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int BUFFER = 0,
    parameter int HOLD   = 0
) (
    input  logic     clk,
    input  logic     reset,
    enabler_if.slave bus
);

    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] pipe_p [BUFFER+1];
    logic             unused_ports;

    function automatic logic [WIDTH-1:0] gate_word(
        input logic             en,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] held
    );
        // Decide on enable first so an unknown data word never leaks while disabled.
        if (en) begin
            return d;
        end
        if (HOLD == int'(HOLD_LAST)) begin
            return held;
        end
        return '0;
    endfunction

    if (BUFFER < 0 || BUFFER > MAX_BUFFER) begin : g_bad_buffer
        $error("enabler: BUFFER=%0d outside legal range 0..%0d", BUFFER, MAX_BUFFER);
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("enabler: WIDTH=%0d must be at least 1", WIDTH);
    end

    if (HOLD != int'(HOLD_ZERO) && HOLD != int'(HOLD_LAST)) begin : g_bad_hold
        $error("enabler: HOLD=%0d must be 0 or 1", HOLD);
    end

    if (HOLD == int'(HOLD_LAST)) begin : g_hold
        enabler_stage #(.WIDTH(WIDTH)) u_hold (
            .clk   (clk),
            .reset (reset),
            .load  (bus.enable),
            .d     (bus.in),
            .q     (hold_q)
        );
    end else begin : g_no_hold
        assign hold_q = '0;
    end

    // p0: gated word
    assign pipe_p[0] = gate_word(bus.enable, bus.in, hold_q);

    for (genvar i = 0; i < BUFFER; i++) begin : g_pipe
        // p(i) -> p(i+1)
        enabler_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .reset (reset),
            .load  (1'b1),
            .d     (pipe_p[i]),
            .q     (pipe_p[i+1])
        );
    end

    assign bus.out = pipe_p[BUFFER];

    // The purely combinational build has no registers to clock or reset.
    assign unused_ports = &{1'b0, clk, reset};

endmodule

// File: tb/tb_enabler.sv
// Randomised and directed bench for enabler across several WIDTH/BUFFER/HOLD builds.
module tb_enabler;

    localparam int NC = 7;

    // Build table: BUFFER, HOLD and data mask per instance.
    localparam int          CB [NC] = '{0, 2, 0, 3, 2, 1, 8};
    localparam int          CH [NC] = '{0, 0, 1, 0, 1, 1, 0};
    localparam logic [7:0]  CM [NC] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF};

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] din;

    int tests = 0;
    int fails = 0;

    logic [7:0] hist [NC][8];
    logic [7:0] hold [NC];
    logic [7:0] act  [NC];

    always #5 clk = ~clk;

    enabler_if #(.WIDTH(8)) if0 ();
    enabler_if #(.WIDTH(8)) if1 ();
    enabler_if #(.WIDTH(8)) if2 ();
    enabler_if #(.WIDTH(8)) if3 ();
    enabler_if #(.WIDTH(8)) if4 ();
    enabler_if #(.WIDTH(1)) if5 ();
    enabler_if #(.WIDTH(8)) if6 ();

    assign if0.enable = en; assign if0.in = din;
    assign if1.enable = en; assign if1.in = din;
    assign if2.enable = en; assign if2.in = din;
    assign if3.enable = en; assign if3.in = din;
    assign if4.enable = en; assign if4.in = din;
    assign if5.enable = en; assign if5.in = din[0];
    assign if6.enable = en; assign if6.in = din;

    assign act[0] = if0.out;
    assign act[1] = if1.out;
    assign act[2] = if2.out;
    assign act[3] = if3.out;
    assign act[4] = if4.out;
    assign act[5] = {7'b0, if5.out};
    assign act[6] = if6.out;

    enabler #(.WIDTH(8), .BUFFER(0), .HOLD(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    enabler #(.WIDTH(8), .BUFFER(2), .HOLD(0)) u1 (.clk(clk), .reset(reset), .bus(if1));
    enabler #(.WIDTH(8), .BUFFER(0), .HOLD(1)) u2 (.clk(clk), .reset(reset), .bus(if2));
    enabler #(.WIDTH(8), .BUFFER(3), .HOLD(0)) u3 (.clk(clk), .reset(reset), .bus(if3));
    enabler #(.WIDTH(8), .BUFFER(2), .HOLD(1)) u4 (.clk(clk), .reset(reset), .bus(if4));
    enabler #(.WIDTH(1), .BUFFER(1), .HOLD(1)) u5 (.clk(clk), .reset(reset), .bus(if5));
    enabler #(.WIDTH(8), .BUFFER(8), .HOLD(0)) u6 (.clk(clk), .reset(reset), .bus(if6));

    // Reference: the word the gate would present now, before any delay.
    function automatic logic [7:0] model_gate(int c, logic e, logic [7:0] d);
        if (e === 1'b1) return d & CM[c];
        if (CH[c] != 0) return hold[c];
        return 8'h00;
    endfunction

    function automatic logic [7:0] model_out(int c);
        if (CB[c] == 0) return model_gate(c, en, din);
        return hist[c][CB[c]-1];
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NC; c++) begin
            hold[c] = 8'h00;
            for (int k = 0; k < 8; k++) hist[c][k] = 8'h00;
        end
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            for (int c = 0; c < NC; c++) begin
                logic [7:0] g;
                g = model_gate(c, en, din);
                for (int k = 7; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = g;
                if (en === 1'b1) hold[c] = din & CM[c];
            end
        end
    end

    always @(negedge reset) model_clear();

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic cmp_all(input string phase);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s_cfg%0d", phase, c), act[c], model_out(c));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3 cmp_all("model_pos");
            @(negedge clk);
            #2 cmp_all("model_neg");
        end
    end

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        din   = 8'hAB;
        model_clear();

        // Combinational gate, no clock needed.
        repeat (4) @(negedge clk);
        #1 chk("b0_disabled_zero", act[0], 8'h00);
        en = 1'b1;
        #1 chk("b0_enabled_pass", act[0], 8'hAB);
        chk("b2_in_reset", act[1], 8'h00);

        // First output exactly BUFFER edges after release.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1 chk("b2_first_edge", act[1], 8'h00);
        @(negedge clk);
        #1 chk("b2_second_edge", act[1], 8'hAB);

        // Hold-last with no pipeline.
        @(negedge clk);
        din = 8'h5A; en = 1'b1;
        @(negedge clk);
        din = 8'hFF; en = 1'b0;
        #1 chk("hold_last", act[2], 8'h5A);

        // Streaming through three stages with a gap.
        @(negedge clk); din = 8'h01; en = 1'b1;
        @(negedge clk); din = 8'h02; en = 1'b0;
        @(negedge clk); din = 8'h03; en = 1'b1;
        @(negedge clk); din = 8'hAB; en = 1'b1;
        #1 chk("b3_stream0", act[3], 8'h01);
        @(negedge clk);
        #1 chk("b3_stream1", act[3], 8'h00);
        @(negedge clk);
        #1 chk("b3_stream2", act[3], 8'h03);

        // Flush full pipelines between edges.
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #2 chk("flush_b2", act[1], 8'hAB & 8'h00);
        chk("flush_b3", act[3], 8'h00);
        chk("flush_b8", act[6], 8'h00);
        en = 1'b0;
        #1 chk("hold_after_reset", act[2], 8'h00);

        // Unknown data while disabled.
        @(negedge clk);
        reset = 1'b1;
        din = 'x;
        #1 chk("x_blocked_b0", act[0], 8'h00);
        chk("x_blocked_hold", act[2], 8'h00);
        @(negedge clk);
        din = 8'h00;

        // Enable toggling every cycle.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            en  = i[0];
            din = 8'($urandom);
        end

        // Random traffic with occasional mid-cycle resets and unknown disabled data.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = 1'b1;
            en    = 1'($urandom);
            din   = 8'($urandom);
            if (!en && $urandom_range(15) == 0) din = 'x;
            if ($urandom_range(63) == 0) #1 reset = 1'b0;
        end

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
